output_writeback_buffer: RTL and testbench
==========================================

// Module: output_writeback_buffer
// PURPOSE
//  Consumes the conv core's output stream (data + x/y/ch tags; no backpressure) and writes each result into the
//  output feature-map memory through a valid/ready write port. Sits directly downstream of the core.
//  Linearises coordinates to addresses, absorbs memory stalls in a small FIFO, counts results, flags loss.
// PARAMETERS
//  DATA_WIDTH          16   width of result word
//  FEATURE_MAP_WIDTH   128  output map width (x range)
//  FEATURE_MAP_HEIGHT  128  output map height (y range)
//  OUTPUT_NB_CHANNELS  2    output channels (ch range)
//  FIFO_DEPTH          8    entries of {addr,data}; power of two, >=2
// PORTS
//  clk        in   1                 clock, all logic on posedge
//  rst        in   1                 synchronous, active-high reset
//  start      in   1                 begin a new layer (clears count/err)
//  in_data    in   DATA_WIDTH        signed result from core
//  in_valid   in   1                 result valid; no ready, must be taken
//  in_x       in   clog2(FM_W)       column tag
//  in_y       in   clog2(FM_H)       row tag
//  in_ch      in   clog2(OUT_CH)     channel tag
//  mem_addr   out  ADDR_W            write address, ADDR_W=clog2(W*H*C)
//  mem_data   out  DATA_WIDTH        write data
//  mem_valid  out  1                 write request
//  mem_ready  in   1                 memory accepts request this cycle
//  count      out  ADDR_W+1          results accepted since start
//  done       out  1                 all TOTAL=W*H*C results written; level until next start
//  err        out  1                 sticky: result dropped (FIFO full or stray input)
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, mem_valid=0, mem_addr=0, mem_data=0, count=0, done=0, err=0.
//  FSM: IDLE --start--> COLLECT; COLLECT --count reaches TOTAL--> DRAIN; DRAIN --FIFO empty--> DONE;
//   DONE --start--> COLLECT. start in COLLECT/DRAIN ignored. start clears count, err, done next cycle.
//  Address: addr = (ch*FM_H + y)*FM_W + x, computed combinationally, unsigned, ADDR_W bits; tags out of range
//   are not checked (core guarantees range).
//  Accept (COLLECT only): in_valid=1 & (!full | pop same cycle) -> push, count++. Full and no pop -> drop, err=1,
//   count still increments (tracks core output, not writes). in_valid in IDLE/DRAIN/DONE -> drop, err=1.
//  Pop: mem_valid & mem_ready. mem_valid = !empty; mem_addr/mem_data driven from FIFO head register.
//  Latency: push at edge N -> mem_valid=1 after edge N (visible cycle N+1) when FIFO was empty; no bypass.
//  Stability: while mem_valid & !mem_ready, mem_addr/mem_data hold.
//  Simultaneous push+pop: allowed at any occupancy incl. full and empty+1; occupancy unchanged.
//  Pointers wrap modulo FIFO_DEPTH; full/empty via extra pointer bit.
//  Last result: the TOTAL-th accept moves COLLECT->DRAIN same edge; DRAIN with FIFO already empty goes to DONE
//   next edge. done=1 only in DONE.
//  rst mid-layer: FIFO contents discarded, all outputs to reset values next edge.
// CONFIGURATION
//  OUTPUT_WB_RELU_EN defined: in_data<0 replaced by 0 before push (fused ReLU); err/count unaffected.
//  Not defined: in_data stored unchanged (two's complement passthrough).
// STRUCTURE
//  Package (shared with core/tb): config_t fields DATA_WIDTH, FEATURE_MAP_WIDTH/HEIGHT, OUTPUT_NB_CHANNELS;
//   wb_state_e {IDLE,COLLECT,DRAIN,DONE}; localparam TOTAL and ADDR_W helper functions.
//  One sub-module: wb_fifo (parameterised sync FIFO, DATA=ADDR_W+DATA_WIDTH, full/empty, push/pop).
//  Top: FSM, address linearisation, count, err, ReLU option.
// TESTING (W=4,H=4,C=2, TOTAL=32, FIFO_DEPTH=8 unless noted)
//  1 start, 32 results back-to-back, mem_ready=1 -> 32 writes, addr=(ch*4+y)*4+x, count=32, done, err=0.
//  2 x=3,y=2,ch=1,data=-5 -> mem_addr=27, mem_data=-5 (0 with OUTPUT_WB_RELU_EN); first mem_valid 1 cycle after in_valid.
//  3 mem_ready=0 for 8 results then 9th -> 9th dropped, err=1, count=9; release ready -> exactly 8 writes.
//  4 FIFO full, mem_ready=1 and in_valid same cycle -> push accepted, err=0, occupancy stays 8.
//  5 in_valid while IDLE or DONE -> no write, err=1; next start clears err/count/done.
//  6 rst asserted after 10 results with 5 queued -> mem_valid=0, count=0, no further writes, state IDLE.

Source files
------------

// File: rtl/output_writeback_buffer_pkg.sv
// Shared definitions for the output write-back buffer, the conv core and benches.
//   config_t          : geometry/width bundle for one output layer
//   wb_state_e        : write-back FSM states
//   wb_total()        : number of results in one layer (W*H*C)
//   wb_clog2_min1()   : tag/address width helper, never returns 0
//   wb_addr_w()       : address width for a W*H*C map
package output_writeback_buffer_pkg;

  typedef struct packed {
    int DATA_WIDTH;
    int FEATURE_MAP_WIDTH;
    int FEATURE_MAP_HEIGHT;
    int OUTPUT_NB_CHANNELS;
  } config_t;

  localparam config_t DEFAULT_CFG = '{
    DATA_WIDTH:         16,
    FEATURE_MAP_WIDTH:  128,
    FEATURE_MAP_HEIGHT: 128,
    OUTPUT_NB_CHANNELS: 2
  };

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } wb_state_e;

  function automatic int wb_total(input int w, input int h, input int c);
    return w * h * c;
  endfunction

  // A single-valued tag still needs a 1-bit port.
  function automatic int wb_clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int wb_addr_w(input int w, input int h, input int c);
    return wb_clog2_min1(w * h * c);
  endfunction

endpackage

// File: rtl/output_writeback_buffer_fifo.sv
// wb_fifo: synchronous FIFO with registered storage, read data taken from the
// head entry. Full/empty use one extra pointer bit; pointers wrap modulo DEPTH.
// Storage is cleared on reset so the head word reads zero out of reset.
// Push while full is only legal together with a pop (head is read before the
// same-edge overwrite). Pop while empty is not allowed.
//   clk, rst            : clock, synchronous active-high reset
//   i_push, i_data      : write request and word
//   i_pop               : remove head entry
//   o_data              : head entry
//   o_full, o_empty     : occupancy flags
module wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr[PW-1:0]] <= i_data;
        r_wr_ptr                <= r_wr_ptr + 1'b1;
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign o_data  = r_mem[r_rd_ptr[PW-1:0]];
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

endmodule

// File: rtl/output_writeback_buffer.sv
// output_writeback_buffer: takes the conv core's result stream (no
// backpressure), linearises x/y/ch tags to addr = (ch*H + y)*W + x, buffers
// {addr,data} in wb_fifo and writes them to the output feature-map memory.
// Counts results per layer, flags any dropped result, reports layer done.
//
// Build option: OUTPUT_WB_RELU_EN -- when defined, negative results are
// stored as 0 (fused ReLU); otherwise data passes through unchanged.
//
// Handshake on the memory port: a write transfers on every edge where
// mem_valid and mem_ready are both 1; while mem_valid=1 and mem_ready=0 the
// request (mem_addr/mem_data) holds. The input side has no ready: a result
// that cannot be queued is lost and sets err.
//
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   start                       : begin new layer (from IDLE/DONE)
//   in_data/in_valid            : result word and strobe
//   in_x/in_y/in_ch             : coordinate tags
//   mem_addr/mem_data/mem_valid : memory write request
//   mem_ready                   : memory accepts request
//   count                       : results seen since start
//   done                        : all results written (level)
//   err                         : sticky drop flag
//   dbg_state                   : FSM state for debug/checkers
module output_writeback_buffer
  import output_writeback_buffer_pkg::*;
#(
  parameter int DATA_WIDTH         = DEFAULT_CFG.DATA_WIDTH,
  parameter int FEATURE_MAP_WIDTH  = DEFAULT_CFG.FEATURE_MAP_WIDTH,
  parameter int FEATURE_MAP_HEIGHT = DEFAULT_CFG.FEATURE_MAP_HEIGHT,
  parameter int OUTPUT_NB_CHANNELS = DEFAULT_CFG.OUTPUT_NB_CHANNELS,
  parameter int FIFO_DEPTH         = 8,
  localparam int X_W    = wb_clog2_min1(FEATURE_MAP_WIDTH),
  localparam int Y_W    = wb_clog2_min1(FEATURE_MAP_HEIGHT),
  localparam int CH_W   = wb_clog2_min1(OUTPUT_NB_CHANNELS),
  localparam int ADDR_W = wb_addr_w(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic [X_W-1:0]        in_x,
  input  logic [Y_W-1:0]        in_y,
  input  logic [CH_W-1:0]       in_ch,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_W:0]       count,
  output logic                  done,
  output logic                  err,
  output wb_state_e             dbg_state
);

  localparam int TOTAL = wb_total(FEATURE_MAP_WIDTH, FEATURE_MAP_HEIGHT, OUTPUT_NB_CHANNELS);
  localparam logic [ADDR_W:0] LAST_COUNT = (ADDR_W+1)'(TOTAL - 1);
  localparam int FW = ADDR_W + DATA_WIDTH;

  wb_state_e             r_state;
  wb_state_e             w_next_state;
  logic [ADDR_W:0]       r_count;
  logic                  r_err;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_drop;
  logic                  w_collect;
  logic                  w_take_start;
  logic                  w_last;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [FW-1:0]         w_head;

  assign w_collect    = (r_state == COLLECT);
  assign w_take_start = start && (r_state == IDLE || r_state == DONE);
  assign w_pop        = !w_empty && mem_ready;
  // A full FIFO still takes a result when the head leaves on the same edge.
  assign w_push       = in_valid && w_collect && (!w_full || w_pop);
  // Covers both a full FIFO in COLLECT and a stray result in any other state.
  assign w_drop       = in_valid && !w_push;
  assign w_last       = in_valid && w_collect && (r_count == LAST_COUNT);

  assign w_addr = ADDR_W'((ADDR_W'(in_ch) * ADDR_W'(FEATURE_MAP_HEIGHT) + ADDR_W'(in_y))
                          * ADDR_W'(FEATURE_MAP_WIDTH) + ADDR_W'(in_x));

`ifdef OUTPUT_WB_RELU_EN
  assign w_data = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign w_data = in_data;
`endif

  wb_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({w_addr, w_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start)   w_next_state = COLLECT;
      COLLECT: if (w_last)  w_next_state = DRAIN;
      DRAIN:   if (w_empty) w_next_state = DONE;
      DONE:    if (start)   w_next_state = COLLECT;
      default:              w_next_state = IDLE;
    endcase
  end

  // count tracks the core's output, so dropped results still advance it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else if (w_take_start) begin
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      if (in_valid && w_collect) r_count <= r_count + 1'b1;
      if (w_drop)                r_err   <= 1'b1;
    end
  end

  assign mem_valid = !w_empty;
  assign mem_addr  = w_head[FW-1 -: ADDR_W];
  assign mem_data  = w_head[DATA_WIDTH-1:0];
  assign count     = r_count;
  assign err       = r_err;
  assign done      = (r_state == DONE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_output_writeback_buffer.sv
module tb_output_writeback_buffer;
  import output_writeback_buffer_pkg::*;

  localparam int DW = 16;
  localparam int FW = 4;
  localparam int FH = 4;
  localparam int NC = 2;
  localparam int AW = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic [1:0]    in_x = '0;
  logic [1:0]    in_y = '0;
  logic [0:0]    in_ch = '0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          mem_valid;
  logic          mem_ready = 1'b1;
  logic [AW:0]   count;
  logic          done;
  logic          err;
  wb_state_e     dbg_state;

  output_writeback_buffer #(
    .DATA_WIDTH         (DW),
    .FEATURE_MAP_WIDTH  (FW),
    .FEATURE_MAP_HEIGHT (FH),
    .OUTPUT_NB_CHANNELS (NC),
    .FIFO_DEPTH         (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_ch     (in_ch),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .count     (count),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

`ifdef OUTPUT_WB_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int n_writes = 0;
  logic [AW+DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [AW+DW-1:0] model(input int x, input int y, input int ch,
                                             input logic [DW-1:0] d);
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    a = AW'((ch * FH + y) * FW + x);
    v = (RELU && d[DW-1]) ? '0 : d;
    return {a, v};
  endfunction

  // ---------------- driver tasks (inputs change #1 after posedge) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input int x, input int y, input int ch, input logic [DW-1:0] d,
                      input bit accepted);
    in_valid = 1'b1;
    in_x     = 2'(x);
    in_y     = 2'(y);
    in_ch    = 1'(ch);
    in_data  = d;
    if (accepted) exp_q.push_back(model(x, y, ch, d));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- scoreboard / monitor (samples on negedge) ----------------
  logic             prev_stall = 1'b0;
  logic [AW-1:0]    prev_addr;
  logic [DW-1:0]    prev_data;
  logic [AW+DW-1:0] mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) begin
        check("hold_addr", 32'(mem_addr), 32'(prev_addr));
        check("hold_data", 32'(mem_data), 32'(prev_data));
      end
      if (mem_valid && mem_ready) begin
        n_writes++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual addr=%0d data=%0d expected no write",
                   mem_addr, mem_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", 32'(mem_addr), 32'(mon_e[AW+DW-1:DW]));
          check("wr_data", 32'(mem_data), 32'(mon_e[DW-1:0]));
        end
      end
      prev_stall = mem_valid && !mem_ready;
      prev_addr  = mem_addr;
      prev_data  = mem_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    int            x;
    int            y;
    int            ch;
    logic [DW-1:0] d;
    int            exp_addr;
    logic [DW-1:0] exp_raw;
  } vec_t;

  vec_t vecs[8];
  int   wbase;
  int   k;

  initial begin
    vecs[0] = '{3, 2, 1, 16'hFFFB, 27, 16'hFFFB};   // -5
    vecs[1] = '{0, 0, 0, 16'd100,   0, 16'd100};
    vecs[2] = '{3, 3, 1, 16'h8000, 31, 16'h8000};   // most negative
    vecs[3] = '{1, 0, 0, 16'h7FFF,  1, 16'h7FFF};   // most positive
    vecs[4] = '{0, 1, 0, 16'hFFFF,  4, 16'hFFFF};   // -1
    vecs[5] = '{0, 0, 1, 16'd0,    16, 16'd0};
    vecs[6] = '{2, 1, 1, 16'd1234, 22, 16'd1234};
    vecs[7] = '{3, 3, 0, 16'd7,    15, 16'd7};

    // reset state
    ticks(2);
    check("rst_mem_valid", 32'(mem_valid), 0);
    check("rst_mem_addr",  32'(mem_addr), 0);
    check("rst_mem_data",  32'(mem_data), 0);
    check("rst_count",     32'(count), 0);
    check("rst_done",      32'(done), 0);
    check("rst_err",       32'(err), 0);
    check("rst_state",     32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    tick();

    // stray result while IDLE
    wbase = n_writes;
    send(1, 1, 0, 16'd55, 1'b0);
    ticks(3);
    check("idle_err",    32'(err), 1);
    check("idle_writes", n_writes - wbase, 0);
    check("idle_count",  32'(count), 0);
    do_start();
    check("start_err",   32'(err), 0);
    check("start_state", 32'(dbg_state), 32'(COLLECT));

    // table: address linearisation, data path, one-cycle latency, no bypass
    for (int i = 0; i < 8; i++) begin
      check("tbl_pre_valid", 32'(mem_valid), 0);
      send(vecs[i].x, vecs[i].y, vecs[i].ch, vecs[i].d, 1'b1);
      check("tbl_valid", 32'(mem_valid), 1);
      check("tbl_addr",  32'(mem_addr), 32'(vecs[i].exp_addr));
      check("tbl_data",  32'(mem_data),
            32'((RELU && vecs[i].exp_raw[DW-1]) ? 16'd0 : vecs[i].exp_raw));
      check("tbl_count", 32'(count), 32'(i + 1));
      tick();
    end
    check("tbl_q_empty", exp_q.size(), 0);
    do_reset();

    // full layer, back-to-back, memory always ready
    do_start();
    wbase = n_writes;
    k = 0;
    for (int ch = 0; ch < NC; ch++)
      for (int y = 0; y < FH; y++)
        for (int x = 0; x < FW; x++) begin
          send(x, y, ch, 16'(k * 1000 - 9000), 1'b1);
          k++;
        end
    check("l1_count", 32'(count), 32);
    check("l1_state_drain", 32'(dbg_state), 32'(DRAIN));
    for (int i = 0; i < 20 && !done; i++) tick();
    check("l1_done",   32'(done), 1);
    check("l1_err",    32'(err), 0);
    check("l1_writes", n_writes - wbase, 32);
    check("l1_q_empty", exp_q.size(), 0);

    // stray result while DONE, then restart clears flags
    wbase = n_writes;
    send(2, 2, 0, 16'd9, 1'b0);
    ticks(2);
    check("done_err",    32'(err), 1);
    check("done_writes", n_writes - wbase, 0);
    check("done_hold",   32'(done), 1);
    do_start();
    check("restart_err",   32'(err), 0);
    check("restart_count", 32'(count), 0);
    check("restart_done",  32'(done), 0);

    // memory stalled: 8 fill the FIFO, 9th is lost
    mem_ready = 1'b0;
    wbase = n_writes;
    for (int i = 0; i < 8; i++) send(i % 4, i / 4, 0, 16'(i + 40), 1'b1);
    check("stall_err_before", 32'(err), 0);
    send(0, 3, 1, 16'd99, 1'b0);
    check("stall_err",   32'(err), 1);
    check("stall_count", 32'(count), 9);
    // start mid-layer is ignored
    do_start();
    check("ign_start_count", 32'(count), 9);
    check("ign_start_err",   32'(err), 1);
    mem_ready = 1'b1;
    ticks(12);
    check("stall_writes", n_writes - wbase, 8);
    check("stall_valid",  32'(mem_valid), 0);
    do_reset();

    // full FIFO with same-cycle pop still accepts the push
    do_start();
    mem_ready = 1'b0;
    wbase = n_writes;
    for (int i = 0; i < 8; i++) send(i % 4, 2 + i / 4, 1, 16'(200 + i), 1'b1);
    mem_ready = 1'b1;
    send(3, 0, 0, 16'd777, 1'b1);
    mem_ready = 1'b0;
    check("full_pp_err",   32'(err), 0);
    check("full_pp_count", 32'(count), 9);
    send(2, 0, 0, 16'd888, 1'b0);   // occupancy still 8, so this is lost
    check("full_again_err", 32'(err), 1);
    mem_ready = 1'b1;
    ticks(12);
    check("full_writes",  n_writes - wbase, 9);
    check("full_q_empty", exp_q.size(), 0);
    do_reset();

    // reset mid-layer with 5 results queued
    do_start();
    for (int i = 0; i < 5; i++) send(i % 4, 0, 0, 16'(300 + i), 1'b1);
    tick();
    mem_ready = 1'b0;
    for (int i = 5; i < 10; i++) send(i % 4, 1, 0, 16'(300 + i), 1'b1);
    check("mid_count", 32'(count), 10);
    check("mid_valid", 32'(mem_valid), 1);
    do_reset();
    check("mid_rst_valid", 32'(mem_valid), 0);
    check("mid_rst_addr",  32'(mem_addr), 0);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
    mem_ready = 1'b1;
    wbase = n_writes;
    ticks(10);
    check("mid_rst_writes", n_writes - wbase, 0);
    check("mid_rst_idle",   32'(dbg_state), 32'(IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
